// File: rtl/jt12_pg_pkg.sv
// Shared constants, types and arithmetic helpers for the jt12 phase generator accumulator.
// Optional LFO vibrato helper is compiled only when JT12_PG_LFO_EN is defined.
package jt12_pg_pkg;

    localparam int NUM_SLOTS_DEF = 24;
    localparam int PHASE_W_DEF   = 20;
    localparam int INC_W         = 17;

    typedef logic [PHASE_W_DEF-1:0] phase_t;
    typedef logic [INC_W-1:0]       inc_t;

    // Shift in 18 bits so block=7 keeps the full fnum<<6 after the halving.
    function automatic inc_t calcBase(input logic [2:0] blk, input logic [10:0] fn);
        logic [INC_W:0] w_shifted;
        w_shifted = {7'b0, fn} << blk;
        return w_shifted[INC_W:1];
    endfunction

    function automatic inc_t addDetune(input inc_t base, input logic [5:0] det);
        inc_t w_ext;
        w_ext = {{(INC_W-6){det[5]}}, det};
        return base + w_ext;
    endfunction

    function automatic phase_t applyMul(input inc_t dt, input logic [3:0] m);
        logic [PHASE_W_DEF:0] w_prod;
        w_prod = {4'b0, dt} * {17'b0, m};
        if (m == 4'd0) begin
            return {4'b0, dt[INC_W-1:1]};
        end
        return w_prod[PHASE_W_DEF-1:0];
    endfunction

`ifdef JT12_PG_LFO_EN
    // fnum + pm ranges over -128..2174, so bit 12 flags negative and bit 11 flags overflow.
    function automatic logic [10:0] clampFnum(input logic [10:0] fn, input logic [7:0] pm);
        logic [12:0] w_sum;
        w_sum = {2'b00, fn} + {{5{pm[7]}}, pm};
        if (w_sum[12]) begin
            return 11'd0;
        end
        if (w_sum[11]) begin
            return 11'h7FF;
        end
        return w_sum[10:0];
    endfunction
`endif

endpackage

// File: rtl/jt12_pg_inc.sv
// Stages S1-S3 of the phase generator: base frequency, detune, multiplier.
// With JT12_PG_LFO_EN defined, i_pm_offset modulates fnum before the block shift.
module jt12_pg_inc
    import jt12_pg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clk_en,
    input  logic [2:0]  i_block,
    input  logic [10:0] i_fnum,
    input  logic [5:0]  i_detune,
    input  logic [3:0]  i_mul,
    input  logic        i_pg_rst,
`ifdef JT12_PG_LFO_EN
    input  logic [7:0]  i_pm_offset,
`endif
    output phase_t      o_inc,
    output logic        o_pg_rst
);

    logic [10:0] w_fnum;

`ifdef JT12_PG_LFO_EN
    assign w_fnum = clampFnum(i_fnum, i_pm_offset);
`else
    assign w_fnum = i_fnum;
`endif

    // Detune and multiplier are sampled with fnum and ride along until their stage uses them.
    inc_t        r_base;
    logic [5:0]  r_det1;
    logic [3:0]  r_mul1;
    logic        r_rst1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base <= '0;
            r_det1 <= '0;
            r_mul1 <= '0;
            r_rst1 <= 1'b0;
        end else if (i_clk_en) begin
            r_base <= calcBase(i_block, w_fnum);
            r_det1 <= i_detune;
            r_mul1 <= i_mul;
            r_rst1 <= i_pg_rst;
        end
    end

    inc_t        r_dt;
    logic [3:0]  r_mul2;
    logic        r_rst2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dt   <= '0;
            r_mul2 <= '0;
            r_rst2 <= 1'b0;
        end else if (i_clk_en) begin
            r_dt   <= addDetune(r_base, r_det1);
            r_mul2 <= r_mul1;
            r_rst2 <= r_rst1;
        end
    end

    phase_t      r_inc;
    logic        r_rst3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inc  <= '0;
            r_rst3 <= 1'b0;
        end else if (i_clk_en) begin
            r_inc  <= applyMul(r_dt, r_mul2);
            r_rst3 <= r_rst2;
        end
    end

    assign o_inc    = r_inc;
    assign o_pg_rst = r_rst3;

endmodule

// File: rtl/jt12_pg_acc.sv
// Time-multiplexed 24-slot phase accumulator (stage S4) fed by jt12_pg_inc (S1-S3).
// Define JT12_PG_LFO_EN to add the pm_offset vibrato input.
module jt12_pg_acc
    import jt12_pg_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int PHASE_W   = PHASE_W_DEF
) (
    input  logic        rst_n,
    input  logic        clk,
    input  logic        clk_en,
    input  logic [2:0]  block,
    input  logic [10:0] fnum,
    input  logic [5:0]  detune_signed,
    input  logic [3:0]  mul,
    input  logic        pg_rst,
`ifdef JT12_PG_LFO_EN
    input  logic [7:0]  pm_offset,
`endif
    output logic [9:0]  phase_op,
    output logic [19:0] phinc_out
);

    phase_t w_inc;
    logic   w_pg_rst;

    jt12_pg_inc u_inc (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clk_en    (clk_en),
        .i_block     (block),
        .i_fnum      (fnum),
        .i_detune    (detune_signed),
        .i_mul       (mul),
        .i_pg_rst    (pg_rst),
`ifdef JT12_PG_LFO_EN
        .i_pm_offset (pm_offset),
`endif
        .o_inc       (w_inc),
        .o_pg_rst    (w_pg_rst)
    );

    logic [PHASE_W-1:0] r_ring [NUM_SLOTS];
    logic [PHASE_W-1:0] w_inc_p;
    logic [PHASE_W-1:0] w_ring_out;
    logic [PHASE_W-1:0] w_new;

    assign w_inc_p    = PHASE_W'(w_inc);
    assign w_ring_out = r_ring[NUM_SLOTS-1];
    assign w_new      = w_pg_rst ? '0 : w_ring_out + w_inc_p;

    // The tail of the ring is the same slot's phase from one full rotation ago.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_ring[i] <= '0;
            end
        end else if (clk_en) begin
            r_ring[0] <= w_new;
            for (int i = 1; i < NUM_SLOTS; i++) begin
                r_ring[i] <= r_ring[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_op  <= '0;
            phinc_out <= '0;
        end else if (clk_en) begin
            phase_op  <= w_new[PHASE_W-1 -: 10];
            phinc_out <= w_pg_rst ? 20'd0 : 20'(w_inc_p);
        end
    end

endmodule

// File: tb/tb_jt12_pg_acc.sv
// Directed self-checking bench for jt12_pg_acc: reset, increments, multiplier edges,
// detune wrap, per-slot pg_rst and clk_en gating, all against hand-computed values.
module tb_jt12_pg_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b0;
    logic [2:0]  block = '0;
    logic [10:0] fnum = '0;
    logic [5:0]  detune_signed = '0;
    logic [3:0]  mul = '0;
    logic        pg_rst = 1'b0;
`ifdef JT12_PG_LFO_EN
    logic [7:0]  pm_offset = '0;
`endif
    logic [9:0]  phase_op;
    logic [19:0] phinc_out;

    jt12_pg_acc dut (
        .rst_n         (rst_n),
        .clk           (clk),
        .clk_en        (clk_en),
        .block         (block),
        .fnum          (fnum),
        .detune_signed (detune_signed),
        .mul           (mul),
        .pg_rst        (pg_rst),
`ifdef JT12_PG_LFO_EN
        .pm_offset     (pm_offset),
`endif
        .phase_op      (phase_op),
        .phinc_out     (phinc_out)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          slot = 0;
    int          rstEdge = -1;
    logic [2:0]  cfgBlock = '0;
    logic [10:0] cfgFnum = '0;
    logic [5:0]  cfgDet = '0;
    logic [3:0]  mulTab [24];

    task automatic checkOutput(input string tag, input logic [19:0] got, input logic [19:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock edge; when enabled, the current slot's inputs are consumed and the slot advances.
    task automatic applyStimulus(input logic en);
        block         = cfgBlock;
        fnum          = cfgFnum;
        detune_signed = cfgDet;
        mul           = mulTab[slot];
        pg_rst        = en && (cyc + 1 == rstEdge);
        clk_en        = en;
        @(posedge clk);
        #1;
        if (en) begin
            cyc++;
            slot = (slot + 1) % 24;
        end
    endtask

    task automatic runTo(input int e);
        while (cyc < e) applyStimulus(1'b1);
    endtask

    task automatic setMulAll(input logic [3:0] m);
        for (int i = 0; i < 24; i++) mulTab[i] = m;
    endtask

    // Asserted between clock edges, so a zero output proves the clear is asynchronous.
    task automatic doReset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checkOutput({tag, " rst phase"}, {10'b0, phase_op}, 20'h0);
        checkOutput({tag, " rst phinc"}, phinc_out, 20'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        cyc     = 0;
        slot    = 0;
        rstEdge = -1;
    endtask

    initial begin
        setMulAll(4'd1);
        $display("[TB] start");

        // Output after enabled edge e belongs to slot (e-4)%24, revisit (e-4)/24+1.
        doReset("init");
        runTo(4);
        checkOutput("zero e4", {10'b0, phase_op}, 20'h0);
        runTo(28);
        checkOutput("zero e28", {10'b0, phase_op}, 20'h0);
        runTo(30);
        checkOutput("zero e30 phinc", phinc_out, 20'h0);

        cfgFnum = 11'h400; cfgBlock = 3'd4; cfgDet = 6'd0; setMulAll(4'd1);
        doReset("basic");
        runTo(3);
        checkOutput("basic e3 phinc", phinc_out, 20'h0);
        runTo(4);
        checkOutput("basic e4 phinc", phinc_out, 20'h02000);
        checkOutput("basic e4 phase", {10'b0, phase_op}, 20'h008);
        runTo(5);
        checkOutput("basic e5 phase", {10'b0, phase_op}, 20'h008);
        runTo(28);
        checkOutput("basic rev2 phase", {10'b0, phase_op}, 20'h010);
        runTo(52);
        checkOutput("basic rev3 phase", {10'b0, phase_op}, 20'h018);

        setMulAll(4'd0);
        doReset("midstream");
        runTo(4);
        checkOutput("mul0 phinc", phinc_out, 20'h01000);
        checkOutput("mul0 phase", {10'b0, phase_op}, 20'h004);
        runTo(28);
        checkOutput("mul0 rev2 phase", {10'b0, phase_op}, 20'h008);

        setMulAll(4'd15);
        doReset("mul15");
        runTo(4);
        checkOutput("mul15 phinc", phinc_out, 20'h1E000);
        checkOutput("mul15 phase", {10'b0, phase_op}, 20'h078);
        runTo(4 + 24 * 8);
        checkOutput("mul15 rev9 wrap", {10'b0, phase_op}, 20'h038);

        cfgFnum = 11'h0; cfgBlock = 3'd0; cfgDet = 6'h3F; setMulAll(4'd1);
        doReset("detune");
        runTo(4);
        checkOutput("detune phinc", phinc_out, 20'h1FFFF);
        checkOutput("detune phase", {10'b0, phase_op}, 20'h07F);
        runTo(28);
        checkOutput("detune rev2 phase", {10'b0, phase_op}, 20'h0FF);

        // Slot 5 is fed at edge 54 with pg_rst and reports at edge 57.
        cfgFnum = 11'h400; cfgBlock = 3'd4; cfgDet = 6'd0; setMulAll(4'd1);
        doReset("pgrst");
        rstEdge = 54;
        runTo(56);
        checkOutput("pgrst slot4", {10'b0, phase_op}, 20'h018);
        runTo(57);
        checkOutput("pgrst slot5 phase", {10'b0, phase_op}, 20'h000);
        checkOutput("pgrst slot5 phinc", phinc_out, 20'h0);
        runTo(58);
        checkOutput("pgrst slot6", {10'b0, phase_op}, 20'h018);
        runTo(80);
        checkOutput("pgrst slot4 next", {10'b0, phase_op}, 20'h020);
        runTo(81);
        checkOutput("pgrst slot5 next", {10'b0, phase_op}, 20'h008);

        // Distinct per-slot multipliers make a spurious advance visible while gated.
        for (int i = 0; i < 24; i++) mulTab[i] = 4'((i % 3) + 1);
        doReset("gate");
        runTo(4);
        checkOutput("gate e4 phase", {10'b0, phase_op}, 20'h008);
        applyStimulus(1'b0);
        checkOutput("gate hold1 phase", {10'b0, phase_op}, 20'h008);
        applyStimulus(1'b0);
        checkOutput("gate hold2 phase", {10'b0, phase_op}, 20'h008);
        checkOutput("gate hold2 phinc", phinc_out, 20'h02000);
        runTo(5);
        checkOutput("gate e5 phase", {10'b0, phase_op}, 20'h010);
        checkOutput("gate e5 phinc", phinc_out, 20'h04000);
        runTo(6);
        checkOutput("gate e6 phase", {10'b0, phase_op}, 20'h018);
        runTo(7);
        checkOutput("gate e7 phase", {10'b0, phase_op}, 20'h008);
        runTo(28);
        checkOutput("gate rev2 slot0", {10'b0, phase_op}, 20'h010);
        runTo(29);
        checkOutput("gate rev2 slot1", {10'b0, phase_op}, 20'h020);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
